btn_event_ctrl: RTL

Front-end controller for the board push-buttons. It synchronises and debounces N raw button inputs and generates PRESS, RELEASE and auto-repeat (REPEAT) events per button. A round-robin scheduler serialises all events onto one valid/ready event stream for the downstream FSM/UI logic. It is the single owner of all button inputs; no other block samples buttons directly.

---
 rtl/btn_ctrl_pkg.sv | 25 ++
 rtl/btn_debounce_ch.sv | 91 +++++++++
 rtl/btn_event_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/btn_ctrl_pkg.sv
// Shared types for the push-button front end: event encoding, pending-slot
// record and small elaboration-time helpers.
package btn_ctrl_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_RELEASE = 2'd1,
        EV_REPEAT  = 2'd2
    } ev_type_t;

    typedef struct packed {
        logic     valid;
        ev_type_t ev_type;
    } slot_t;

    // Index width; a 2-button build still needs a 1-bit index.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, debounced level
// and hold/auto-repeat timer. Emits a combinational one-cycle event strobe.
module btn_debounce_ch
    import btn_ctrl_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     btn_i,
    output logic     state_o,
    output logic     strobe_o,
    output ev_type_t type_o
);

    localparam int HOLD_W = $clog2(max_i(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    logic              s0_q, s0_d;
    logic              s1_q, s1_d;
    logic              state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rep_phase_q, rep_phase_d;
    logic              toggle;
    logic              rep_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            state_q     <= 1'b0;
            cnt_q       <= '0;
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    always_comb begin
        s0_d = btn_i;
        s1_d = s0_q;

        toggle  = (s1_q != state_q) && (&cnt_q);
        state_d = toggle ? s1_q : state_q;

        if ((s1_q == state_q) || toggle) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // First repeat after HOLD_CYCLES, then the timer restarts in the
        // shorter REPEAT_CYCLES phase.
        if (rep_phase_q) begin
            rep_hit = state_q && (hold_q == HOLD_W'(REPEAT_CYCLES - 1));
        end else begin
            rep_hit = state_q && (hold_q == HOLD_W'(HOLD_CYCLES - 1));
        end

        hold_d      = hold_q;
        rep_phase_d = rep_phase_q;
        if (toggle || !state_q) begin
            hold_d      = '0;
            rep_phase_d = 1'b0;
        end else if (rep_hit) begin
            hold_d      = '0;
            rep_phase_d = 1'b1;
        end else if (hold_q != {HOLD_W{1'b1}}) begin
            hold_d = hold_q + 1'b1;
        end

        // A level change outranks a repeat landing on the same cycle.
        strobe_o = toggle || rep_hit;
        if (toggle) begin
            type_o = s1_q ? EV_PRESS : EV_RELEASE;
        end else begin
            type_o = EV_REPEAT;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Button front end: per-button debounce channels feeding one-deep pending
// slots, drained by a round-robin scheduler onto a single valid/ready stream.
module btn_event_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int CNT_W         = 16,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_i,
    output logic [N_BTN-1:0]         btn_state_o,
    output logic                     ev_valid_o,
    input  logic                     ev_ready_i,
    output logic [id_w(N_BTN)-1:0]   ev_id_o,
    output logic [1:0]               ev_type_o,
    output logic                     drop_o,
    output logic [id_w(N_BTN)-1:0]   drop_id_o
);

    localparam int ID_W = id_w(N_BTN);

    logic [N_BTN-1:0] strobe;
    ev_type_t         strobe_type [N_BTN];

    slot_t            slot_q [N_BTN];
    slot_t            slot_d [N_BTN];

    logic             ev_valid_q, ev_valid_d;
    logic [ID_W-1:0]  ev_id_q, ev_id_d;
    ev_type_t         ev_type_q, ev_type_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic             drop_q, drop_d;
    logic [ID_W-1:0]  drop_id_q, drop_id_d;

    logic             out_free;
    logic             gnt;
    logic [ID_W-1:0]  gnt_idx;
    ev_type_t         gnt_type;
    int               scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_debounce_ch #(
                .CNT_W         (CNT_W),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .btn_i    (btn_i[gi]),
                .state_o  (btn_state_o[gi]),
                .strobe_o (strobe[gi]),
                .type_o   (strobe_type[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                slot_q[i] <= '0;
            end
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ev_type_q  <= EV_PRESS;
            rr_q       <= ID_W'(N_BTN - 1);
            drop_q     <= 1'b0;
            drop_id_q  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                slot_q[i] <= slot_d[i];
            end
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            ev_type_q  <= ev_type_d;
            rr_q       <= rr_d;
            drop_q     <= drop_d;
            drop_id_q  <= drop_id_d;
        end
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        out_free = !ev_valid_q || ev_ready_i;
        gnt      = 1'b0;
        gnt_idx  = '0;
        gnt_type = EV_PRESS;
        scan_idx = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            scan_idx = (int'(rr_q) + k) % N_BTN;
            if (!gnt && slot_q[scan_idx].valid) begin
                gnt      = 1'b1;
                gnt_idx  = ID_W'(scan_idx);
                gnt_type = slot_q[scan_idx].ev_type;
            end
        end
        gnt = gnt && out_free;
    end

    // A grant frees its slot first, so a strobe on the same edge lands
    // without counting as an overwrite.
    always_comb begin
        drop_d    = 1'b0;
        drop_id_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            slot_d[i] = slot_q[i];
            if (gnt && (gnt_idx == ID_W'(i))) begin
                slot_d[i].valid = 1'b0;
            end
            if (strobe[i]) begin
                if (strobe_type[i] != EV_REPEAT) begin
                    if (slot_d[i].valid && !drop_d) begin
                        drop_d    = 1'b1;
                        drop_id_d = ID_W'(i);
                    end
                    slot_d[i].valid   = 1'b1;
                    slot_d[i].ev_type = strobe_type[i];
                end else if (!slot_d[i].valid) begin
                    slot_d[i].valid   = 1'b1;
                    slot_d[i].ev_type = EV_REPEAT;
                end
            end
        end
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        ev_type_d  = ev_type_q;
        rr_d       = rr_q;
        if (out_free) begin
            ev_valid_d = gnt;
        end
        if (gnt) begin
            ev_id_d   = gnt_idx;
            ev_type_d = gnt_type;
            rr_d      = gnt_idx;
        end
    end

    assign ev_valid_o = ev_valid_q;
    assign ev_id_o    = ev_id_q;
    assign ev_type_o  = ev_type_q;
    assign drop_o     = drop_q;
    assign drop_id_o  = drop_id_q;

endmodule
